// File: rtl/rtc_bridge_pkg.sv
// Shared definitions for the RTC bridge: register map, field masks,
// status bit positions and the bridge FSM encoding.
package rtc_bridge_pkg;

    localparam int NUM_FIELDS = 7;

    localparam logic [2:0] ADDR_SEC    = 3'd0;
    localparam logic [2:0] ADDR_MIN    = 3'd1;
    localparam logic [2:0] ADDR_HOUR   = 3'd2;
    localparam logic [2:0] ADDR_DAY    = 3'd3;
    localparam logic [2:0] ADDR_WDAY   = 3'd4;
    localparam logic [2:0] ADDR_MONTH  = 3'd5;
    localparam logic [2:0] ADDR_YEAR   = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_PENDING = 6;
    localparam int STAT_VALID   = 5;
    localparam int STAT_VL      = 4;

    localparam int VL_BIT = 55;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_PULSE = 3'd1,
        ST_GET_WAIT  = 3'd2,
        ST_SET_PULSE = 3'd3,
        ST_SET_WAIT  = 3'd4
    } state_t;

    // Bits that carry meaning in each BCD field of the chip
    function automatic logic [7:0] field_mask(input int idx);
        case (idx)
            0:       return 8'h7F;
            1:       return 8'h7F;
            2:       return 8'h3F;
            3:       return 8'h3F;
            4:       return 8'h07;
            5:       return 8'h1F;
            default: return 8'hFF;
        endcase
    endfunction

    // Field 0 (seconds) occupies the most significant byte of the packed word
    function automatic logic [7:0] get_field(input logic [55:0] d, input int idx);
        return d[55-8*idx -: 8];
    endfunction

endpackage

// File: rtl/rtc_bridge_if.sv
// Host register bus of the RTC bridge: staging writes, commit request and
// combinational shadow/status read-back.
interface rtc_bridge_if;
    logic [2:0] host_addr;
    logic       host_wr;
    logic [7:0] host_wdata;
    logic       host_commit;
    logic [7:0] host_rdata;

    modport master (
        output host_addr, host_wr, host_wdata, host_commit,
        input  host_rdata
    );

    modport slave (
        input  host_addr, host_wr, host_wdata, host_commit,
        output host_rdata
    );
endinterface

// File: rtl/rtc_bridge_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module rtc_bridge_timer #(
    parameter int WIDTH = 32
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge mclk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/rtc_bridge.sv
// Bridges a host register file to an RTC controller: periodic reads into a
// shadow copy, host-staged time written to the chip on commit.
module rtc_bridge
    import rtc_bridge_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50_000_000,
    parameter int PULSE_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 65536
) (
    input  logic         mclk,
    input  logic         reset,
    rtc_bridge_if.slave  host,
    output logic         rtc_get,
    output logic         rtc_set,
    output logic [55:0]  rtc_wr_data,
    input  logic [55:0]  rtc_rd_data,
    output logic [55:0]  time_out,
    output logic         rtc_valid,
    output logic         rtc_vl,
    output logic         busy
);

    localparam logic [31:0] PULSE_LOAD   = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] REFRESH_LOAD = 32'(REFRESH_CYCLES - 1);

    state_t      state, state_nxt;
    logic        ph_load;
    logic [31:0] ph_val;
    logic        ph_done;
    logic        ref_load;
    logic        ref_done;
    logic        capture;
    logic        set_entry;

    logic [7:0]  shadow  [NUM_FIELDS];
    logic [7:0]  staging [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] dirty;
    logic        pending;
    logic [55:0] staging_masked;

    rtc_bridge_timer #(.WIDTH(32)) u_phase_tmr (
        .mclk     (mclk),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (1'b1),
        .done     (ph_done)
    );

    // Reloaded whenever an operation starts; only runs down while idle
    rtc_bridge_timer #(.WIDTH(32)) u_refresh_tmr (
        .mclk     (mclk),
        .reset    (reset),
        .load     (ref_load),
        .load_val (REFRESH_LOAD),
        .en       (state == ST_IDLE),
        .done     (ref_done)
    );

    always_ff @(posedge mclk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_load   = 1'b0;
        ph_val    = PULSE_LOAD;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host.host_commit || pending) begin
                    state_nxt = ST_SET_PULSE;
                    ph_load   = 1'b1;
                end else if (ref_done) begin
                    state_nxt = ST_GET_PULSE;
                    ph_load   = 1'b1;
                end
            end
            ST_GET_PULSE: begin
                if (ph_done) begin
                    state_nxt = ST_GET_WAIT;
                    ph_load   = 1'b1;
                    ph_val    = SETTLE_LOAD;
                end
            end
            ST_SET_PULSE: begin
                if (ph_done) begin
                    state_nxt = ST_SET_WAIT;
                    ph_load   = 1'b1;
                    ph_val    = SETTLE_LOAD;
                end
            end
            ST_GET_WAIT, ST_SET_WAIT: begin
                if (ph_done) begin
                    state_nxt = ST_IDLE;
                    capture   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign set_entry = (state == ST_IDLE) && (state_nxt == ST_SET_PULSE);
    assign ref_load  = ph_load && (state == ST_IDLE);

    assign rtc_get = (state == ST_GET_PULSE);
    assign rtc_set = (state == ST_SET_PULSE);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        staging_masked = '0;
        time_out       = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            staging_masked[55-8*i -: 8] = staging[i] & field_mask(i);
            time_out[55-8*i -: 8]       = shadow[i];
        end
    end

    always_comb begin
        host.host_rdata = '0;
        if (host.host_addr == ADDR_STATUS) begin
            host.host_rdata[STAT_BUSY]    = busy;
            host.host_rdata[STAT_PENDING] = pending;
            host.host_rdata[STAT_VALID]   = rtc_valid;
            host.host_rdata[STAT_VL]      = rtc_vl;
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (host.host_addr == 3'(i)) begin
                    host.host_rdata = shadow[i];
                end
            end
        end
    end

    // A host write in the same cycle as a capture keeps the host's value
    always_ff @(posedge mclk) begin
        if (!reset) begin
            pending     <= 1'b0;
            rtc_valid   <= 1'b0;
            rtc_vl      <= 1'b0;
            rtc_wr_data <= '0;
            dirty       <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow[i]  <= '0;
                staging[i] <= '0;
            end
        end else begin
            if (set_entry) begin
                pending     <= 1'b0;
                rtc_wr_data <= staging_masked;
            end else if (host.host_commit && busy) begin
                pending <= 1'b1;
            end
            if (capture) begin
                rtc_valid <= 1'b1;
                rtc_vl    <= rtc_rd_data[VL_BIT];
            end
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (capture) begin
                    shadow[i] <= get_field(rtc_rd_data, i) & field_mask(i);
                end
                if (host.host_wr && host.host_addr == 3'(i)) begin
                    staging[i] <= host.host_wdata;
                    dirty[i]   <= 1'b1;
                end else begin
                    if (capture && !dirty[i]) begin
                        staging[i] <= get_field(rtc_rd_data, i) & field_mask(i);
                    end
                    if (set_entry) begin
                        dirty[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_bridge.sv
// Randomised and directed bench for rtc_bridge against a per-operation
// reference model of the bridge behaviour.
module tb_rtc_bridge;

    localparam int R = 1000;
    localparam int P = 4;
    localparam int S = 16;

    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic        rtc_get, rtc_set, rtc_valid, rtc_vl, busy;
    logic [55:0] rtc_wr_data, rtc_rd_data, time_out;

    rtc_bridge_if bus ();

    rtc_bridge #(
        .REFRESH_CYCLES (R),
        .PULSE_CYCLES   (P),
        .SETTLE_CYCLES  (S)
    ) dut (
        .mclk        (mclk),
        .reset       (reset),
        .host        (bus),
        .rtc_get     (rtc_get),
        .rtc_set     (rtc_set),
        .rtc_wr_data (rtc_wr_data),
        .rtc_rd_data (rtc_rd_data),
        .time_out    (time_out),
        .rtc_valid   (rtc_valid),
        .rtc_vl      (rtc_vl),
        .busy        (busy)
    );

    always #5 mclk = ~mclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: an operation is one block of P pulse cycles followed
    // by S settle cycles; idle time counts up towards the refresh point.
    logic [7:0]  msk [7] = '{8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h07, 8'h1F, 8'hFF};
    int          m_op;
    int          m_left;
    int          m_idle;
    logic [7:0]  m_shadow [7];
    logic [7:0]  m_stage  [7];
    bit          m_dirty  [7];
    bit          m_pend, m_valid, m_vl;
    logic [55:0] m_wr;

    task automatic model_step();
        bit was_busy;
        logic [55:0] snap;
        if (!reset) begin
            m_op = 0; m_left = 0; m_idle = R - 1;
            m_pend = 0; m_valid = 0; m_vl = 0; m_wr = '0;
            for (int i = 0; i < 7; i++) begin
                m_shadow[i] = '0; m_stage[i] = '0; m_dirty[i] = 0;
            end
            return;
        end
        was_busy = (m_op != 0);
        if (m_op == 0) begin
            if (bus.host_commit || m_pend) begin
                snap = '0;
                for (int i = 0; i < 7; i++) begin
                    snap[55-8*i -: 8] = m_stage[i] & msk[i];
                    m_dirty[i] = 0;
                end
                m_wr = snap; m_pend = 0; m_op = 2; m_left = P + S; m_idle = 0;
            end else if (m_idle >= R - 1) begin
                m_op = 1; m_left = P + S; m_idle = 0;
            end else begin
                m_idle++;
            end
        end else if (m_left == 1) begin
            for (int i = 0; i < 7; i++) begin
                m_shadow[i] = rtc_rd_data[55-8*i -: 8] & msk[i];
                if (!m_dirty[i]) m_stage[i] = m_shadow[i];
            end
            m_valid = 1; m_vl = rtc_rd_data[55]; m_op = 0;
        end else begin
            m_left--;
        end
        if (bus.host_commit && was_busy) m_pend = 1;
        if (bus.host_wr && bus.host_addr != 3'd7) begin
            m_stage[bus.host_addr] = bus.host_wdata;
            m_dirty[bus.host_addr] = 1;
        end
    endtask

    task automatic check_outputs();
        logic [55:0] exp_t;
        logic [7:0]  exp_rd;
        exp_t = '0;
        for (int i = 0; i < 7; i++) exp_t[55-8*i -: 8] = m_shadow[i];
        if (bus.host_addr == 3'd7)
            exp_rd = {(m_op != 0), m_pend, m_valid, m_vl, 4'b0};
        else
            exp_rd = m_shadow[bus.host_addr];
        chk("rtc_get",   64'(rtc_get),     64'(m_op == 1 && m_left > S));
        chk("rtc_set",   64'(rtc_set),     64'(m_op == 2 && m_left > S));
        chk("busy",      64'(busy),        64'(m_op != 0));
        chk("rtc_valid", 64'(rtc_valid),   64'(m_valid));
        chk("rtc_vl",    64'(rtc_vl),      64'(m_vl));
        chk("time_out",  64'(time_out),    64'(exp_t));
        chk("wr_data",   64'(rtc_wr_data), 64'(m_wr));
        chk("rdata",     64'(bus.host_rdata), 64'(exp_rd));
    endtask

    task automatic tick();
        model_step();
        @(posedge mclk);
        #1;
        check_outputs();
    endtask

    task automatic wait_get(input int budget);
        int n;
        n = 0;
        while (rtc_get !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (rtc_get !== 1'b1) chk("wait_get_timeout", 64'(n), 64'(budget + 1));
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        bus.host_addr = a; bus.host_wdata = d; bus.host_wr = 1'b1;
        tick();
        bus.host_wr = 1'b0;
    endtask

    task automatic commit();
        bus.host_commit = 1'b1;
        tick();
        bus.host_commit = 1'b0;
    endtask

    initial begin
        int n, rises, highs;
        logic prev;
        bus.host_addr = 3'd0; bus.host_wr = 1'b0; bus.host_wdata = 8'h00; bus.host_commit = 1'b0;
        rtc_rd_data = 56'h45_30_12_15_03_06_24;

        repeat (3) tick();
        chk("rst_get",   64'(rtc_get),   64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_valid", 64'(rtc_valid), 64'd0);
        chk("rst_time",  64'(time_out),  64'd0);

        // First read starts straight out of reset
        reset = 1'b1;
        tick();
        chk("first_get", 64'(rtc_get), 64'd1);
        repeat (P + S - 1) tick();
        chk("valid_before_capture", 64'(rtc_valid), 64'd0);
        tick();
        chk("first_time", 64'(time_out), 64'h45_30_12_15_03_06_24);
        chk("first_valid", 64'(rtc_valid), 64'd1);

        // Voltage-low flag on the seconds byte
        rtc_rd_data = 56'hC5_30_12_15_03_06_24;
        wait_get(R + 50);
        repeat (P + S) tick();
        chk("vl_sec", 64'(time_out[55:48]), 64'h45);
        chk("vl_flag", 64'(rtc_vl), 64'd1);
        bus.host_addr = 3'd7;
        #1;
        chk("vl_status", 64'(bus.host_rdata), 64'h30);

        // Host-edited hour, other fields from the last capture
        rtc_rd_data = 56'h59_58_23_31_06_12_99;
        host_write(3'd2, 8'h23);
        commit();
        chk("set_high", 64'(rtc_set), 64'd1);
        chk("set_wr_data", 64'(rtc_wr_data), 64'h45_30_23_15_03_06_24);
        repeat (P + S) tick();

        // Two commits while a read settles collapse into one set
        wait_get(R + 50);
        repeat (P + 2) tick();
        commit();
        repeat (3) tick();
        commit();
        rises = 0; highs = 0; prev = rtc_set;
        for (int i = 0; i < 2 * (P + S) + 10; i++) begin
            tick();
            if (rtc_set && !prev) rises++;
            if (rtc_set) highs++;
            prev = rtc_set;
        end
        chk("collapse_rises", 64'(rises), 64'd1);
        chk("collapse_len", 64'(highs), 64'(P));

        // Commit on the very cycle the refresh timer expires
        n = 0;
        while (!(m_op == 0 && m_idle == R - 1 && !m_pend) && n < R + 200) begin
            tick();
            n++;
        end
        commit();
        chk("tie_set", 64'(rtc_set), 64'd1);
        chk("tie_get", 64'(rtc_get), 64'd0);
        n = 0;
        while (rtc_get !== 1'b1 && n < R + P + S + 50) begin
            tick();
            n++;
        end
        chk("refresh_gap", 64'(n), 64'(P + S + R));
        repeat (P + S + 2) tick();

        // Reset in the middle of a set pulse
        commit();
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_set",   64'(rtc_set),     64'd0);
        chk("mid_rst_get",   64'(rtc_get),     64'd0);
        chk("mid_rst_busy",  64'(busy),        64'd0);
        chk("mid_rst_valid", 64'(rtc_valid),   64'd0);
        chk("mid_rst_vl",    64'(rtc_vl),      64'd0);
        chk("mid_rst_time",  64'(time_out),    64'd0);
        chk("mid_rst_wr",    64'(rtc_wr_data), 64'd0);
        reset = 1'b1;

        // Random host traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.host_addr   = 3'($urandom_range(0, 7));
            bus.host_wr     = ($urandom_range(0, 9) == 0);
            bus.host_wdata  = 8'($urandom);
            bus.host_commit = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0)
                rtc_rd_data = {24'($urandom), 32'($urandom)};
            tick();
        end
        bus.host_wr = 1'b0;
        bus.host_commit = 1'b0;
        repeat (P + S + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
